// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings and
// mem_sel owner encodings, plus the state-to-owner mapping.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_D    = 2'b10,
    ARB_DMA  = 2'b11
  } arb_state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_IF   = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_DMA  = 2'b11;

  // Owner code presented on mem_sel for a given arbiter state.
  function automatic logic [1:0] sel_of(arb_state_t st);
    case (st)
      ARB_IF:  return SEL_IF;
      ARB_D:   return SEL_D;
      ARB_DMA: return SEL_DMA;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// Fixed-latency access timer for the memory bus arbiter. Counts the cycles
// of one CPU access (0 .. MEM_LATENCY-1) and flags its first and last cycle.
// Held at zero while clr is high, so it restarts on every state entry.
module mem_bus_arbiter_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic first,
  output logic last
);

  localparam int TW = $clog2(MEM_LATENCY + 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(MEM_LATENCY - 1);

  logic [TW-1:0] count;

  // Count up to the last access cycle and stop there; never wraps.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (count != LAST_CNT) begin
      count <= count + 1'b1;
    end
  end

  assign first = (count == '0);
  assign last  = (count == LAST_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory port arbiter between CPU instruction fetch, CPU data access
// and the DMA controller. Runs fixed-latency CPU accesses, produces the
// IF/D stall signals and hands the bus to DMA only between CPU accesses.
// Optional feature: define ARB_DMA_TIMEOUT_EN to bound how long DMA may hold
// the bus while the CPU is waiting, after which one CPU access is forced.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int DMA_MAX_HOLD = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       if_req,
  input  logic       d_req,
  input  logic       dma_br,
  output logic       dma_bg,
  output logic [1:0] mem_sel,
  output logic       mem_start,
  output logic       if_done,
  output logic       d_done,
  output logic       if_stall,
  output logic       d_stall
);

  if (WORD_SIZE < 1 || MEM_LATENCY < 1 || DMA_MAX_HOLD < 1) begin : g_param_check
    $error("mem_bus_arbiter: WORD_SIZE, MEM_LATENCY and DMA_MAX_HOLD must be >= 1");
  end

  arb_state_t state, state_next;
  logic       in_access, acc_first, acc_last, timer_clr;
  logic       cpu_req, dma_ok, hold_expired;

  assign in_access = (state == ARB_IF) || (state == ARB_D);
  assign cpu_req   = if_req | d_req;
  // Restart the timer outside accesses and on the last cycle, so every
  // new access (including back-to-back ones) starts from zero.
  assign timer_clr = ~in_access | acc_last;

  mem_bus_arbiter_timer #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (timer_clr),
    .first  (acc_first),
    .last   (acc_last)
  );

`ifdef ARB_DMA_TIMEOUT_EN
  localparam int HW = $clog2(DMA_MAX_HOLD + 1);

  logic [HW-1:0] hold;
  logic          preempt;

  assign hold_expired = (state == ARB_DMA) && cpu_req && (hold == HW'(DMA_MAX_HOLD - 1));
  // After a preemption DMA sits out the next decision so one CPU access runs.
  assign dma_ok       = dma_br & ~preempt;

  // Count DMA-owned cycles during which the CPU is waiting; remember a
  // preemption until the following IDLE decision has been made.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold    <= '0;
      preempt <= 1'b0;
    end else begin
      if (state != ARB_DMA) begin
        hold <= '0;
      end else if (cpu_req) begin
        hold <= hold + 1'b1;
      end
      if (hold_expired) begin
        preempt <= 1'b1;
      end else if (state == ARB_IDLE) begin
        preempt <= 1'b0;
      end
    end
  end
`else
  assign hold_expired = 1'b0;
  assign dma_ok       = dma_br;
`endif

  // Fixed priority at a decision point: DMA, then D (older stage), then IF.
  function automatic arb_state_t pick_owner(logic dma, logic d, logic i);
    if (dma)    return ARB_DMA;
    else if (d) return ARB_D;
    else if (i) return ARB_IF;
    else        return ARB_IDLE;
  endfunction

  // State register; reset abandons any access or DMA tenure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision and Moore outputs derived from the current state.
  always_comb begin
    state_next = state;
    mem_sel    = sel_of(state);
    dma_bg     = 1'b0;
    mem_start  = 1'b0;
    if_done    = 1'b0;
    d_done     = 1'b0;
    case (state)
      ARB_IDLE: begin
        state_next = pick_owner(dma_ok, d_req, if_req);
      end
      ARB_IF: begin
        mem_start = acc_first;
        if_done   = acc_last;
        if (acc_last) state_next = pick_owner(dma_ok, d_req, if_req);
      end
      ARB_D: begin
        mem_start = acc_first;
        d_done    = acc_last;
        if (acc_last) state_next = pick_owner(dma_ok, d_req, if_req);
      end
      ARB_DMA: begin
        dma_bg = 1'b1;
        if (!dma_br || hold_expired) state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Stalls are held low while reset is asserted so the block is fully quiet.
  assign if_stall = reset_n & if_req & ~if_done;
  assign d_stall  = reset_n & d_req & ~d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter (MEM_LATENCY=2).
// Each stimulus cycle pushes its hand-computed expected output bundle; a
// monitor on the falling edge pops and compares it against the DUT.
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic       if_req, d_req, dma_br;
  logic       dma_bg;
  logic [1:0] mem_sel;
  logic       mem_start, if_done, d_done, if_stall, d_stall;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } vec_t;

  vec_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  mem_bus_arbiter #(
    .WORD_SIZE   (16),
    .MEM_LATENCY (2),
    .DMA_MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .d_req    (d_req),
    .dma_br   (dma_br),
    .dma_bg   (dma_bg),
    .mem_sel  (mem_sel),
    .mem_start(mem_start),
    .if_done  (if_done),
    .d_done   (d_done),
    .if_stall (if_stall),
    .d_stall  (d_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle: {dma_bg, mem_sel, mem_start, if_done, d_done, if_stall, d_stall}
  function automatic logic [7:0] ex(bit bg, bit [1:0] sel, bit st, bit ifd, bit dd,
                                    bit ifs, bit ds);
    return {bg, sel, st, ifd, dd, ifs, ds};
  endfunction

  localparam logic [7:0] ZERO = 8'h00;

  // One clock cycle of stimulus plus its expected outputs.
  task automatic cyc(input bit rn, input bit i, input bit d, input bit b,
                     input logic [7:0] exp, input string tag);
    vec_t v;
    @(posedge clk);
    #1;
    reset_n = rn;
    if_req  = i;
    d_req   = d;
    dma_br  = b;
    v.exp   = exp;
    v.tag   = tag;
    q.push_back(v);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      vec_t v;
      logic [7:0] act;
      v   = q.pop_front();
      act = {dma_bg, mem_sel, mem_start, if_done, d_done, if_stall, d_stall};
      n_vec++;
      if (act !== v.exp) begin
        n_miss++;
        $display("FAIL %s: got bg/sel/start/ifd/dd/ifs/ds=%b required %b", v.tag, act, v.exp);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    dma_br  = 1'b0;
    repeat (2) @(posedge clk);

    cyc(0, 0, 0, 0, ZERO, "reset");

    // IF held: back-to-back fetches, done every 2nd cycle
    cyc(1, 1, 0, 0, ex(0, 2'b00, 0, 0, 0, 1, 0), "t1_idle");
    cyc(1, 1, 0, 0, ex(0, 2'b01, 1, 0, 0, 1, 0), "t1_if_a0");
    cyc(1, 1, 0, 0, ex(0, 2'b01, 0, 1, 0, 0, 0), "t1_if_a1");
    cyc(1, 1, 0, 0, ex(0, 2'b01, 1, 0, 0, 1, 0), "t1_if_b0");
    cyc(1, 1, 0, 0, ex(0, 2'b01, 0, 1, 0, 0, 0), "t1_if_b1");
    cyc(1, 0, 0, 0, ex(0, 2'b01, 1, 0, 0, 0, 0), "t1_drop0");
    cyc(1, 0, 0, 0, ex(0, 2'b01, 0, 1, 0, 0, 0), "t1_drop1");
    cyc(1, 0, 0, 0, ZERO,                        "t1_idle_end");

    // IF and D together: D first, then IF with no bubble
    cyc(1, 1, 1, 0, ex(0, 2'b00, 0, 0, 0, 1, 1), "t2_idle");
    cyc(1, 1, 1, 0, ex(0, 2'b10, 1, 0, 0, 1, 1), "t2_d0");
    cyc(1, 1, 0, 0, ex(0, 2'b10, 0, 0, 1, 1, 0), "t2_d1");
    cyc(1, 1, 0, 0, ex(0, 2'b01, 1, 0, 0, 1, 0), "t2_if0");
    cyc(1, 0, 0, 0, ex(0, 2'b01, 0, 1, 0, 0, 0), "t2_if1");
    cyc(1, 0, 0, 0, ZERO,                        "t2_idle_end");

    // DMA request mid-IF waits for completion, then pending IF resumes
    cyc(1, 1, 0, 0, ex(0, 2'b00, 0, 0, 0, 1, 0), "t3_idle");
    cyc(1, 1, 0, 1, ex(0, 2'b01, 1, 0, 0, 1, 0), "t3_if0");
    cyc(1, 1, 0, 1, ex(0, 2'b01, 0, 1, 0, 0, 0), "t3_if1");
    cyc(1, 1, 0, 1, ex(1, 2'b11, 0, 0, 0, 1, 0), "t3_dma");
    cyc(1, 1, 0, 0, ex(1, 2'b11, 0, 0, 0, 1, 0), "t3_br_low");
    cyc(1, 1, 0, 0, ex(0, 2'b00, 0, 0, 0, 1, 0), "t3_bg_drop");
    cyc(1, 1, 0, 0, ex(0, 2'b01, 1, 0, 0, 1, 0), "t3_if_re0");
    cyc(1, 0, 0, 0, ex(0, 2'b01, 0, 1, 0, 0, 0), "t3_if_re1");
    cyc(1, 0, 0, 0, ZERO,                        "t3_idle_end");

    // Reset in the first cycle of a D access: no done pulse afterwards
    cyc(1, 0, 1, 0, ex(0, 2'b00, 0, 0, 0, 0, 1), "t4_idle");
    cyc(0, 0, 1, 0, ex(0, 2'b10, 1, 0, 0, 0, 0), "t4_rst_in_d");
    cyc(1, 0, 0, 0, ZERO,                        "t4_after_d_rst");
    cyc(1, 0, 0, 0, ZERO,                        "t4_no_done");

    // Reset during DMA ownership drops the grant on the next cycle
    cyc(1, 0, 0, 1, ZERO,                        "t4_idle_br");
    cyc(1, 0, 0, 1, ex(1, 2'b11, 0, 0, 0, 0, 0), "t4_dma");
    cyc(0, 0, 0, 1, ex(1, 2'b11, 0, 0, 0, 0, 0), "t4_rst_in_dma");
    cyc(1, 0, 0, 1, ZERO,                        "t4_bg_low");
    cyc(1, 0, 0, 0, ex(1, 2'b11, 0, 0, 0, 0, 0), "t4_regrant");
    cyc(1, 0, 0, 0, ZERO,                        "t4_end");

`ifdef ARB_DMA_TIMEOUT_EN
    // DMA preempted after 4 waiting cycles, one D access, then regranted
    cyc(1, 0, 1, 1, ex(0, 2'b00, 0, 0, 0, 0, 1), "t5_idle");
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 1, 1, ex(1, 2'b11, 0, 0, 0, 0, 1), "t5_hold");
    cyc(1, 0, 1, 1, ex(0, 2'b00, 0, 0, 0, 0, 1), "t5_preempt");
    cyc(1, 0, 1, 1, ex(0, 2'b10, 1, 0, 0, 0, 1), "t5_d0");
    cyc(1, 0, 1, 1, ex(0, 2'b10, 0, 0, 1, 0, 0), "t5_d1");
    cyc(1, 0, 1, 1, ex(1, 2'b11, 0, 0, 0, 0, 1), "t5_regrant");
    cyc(1, 0, 0, 0, ex(1, 2'b11, 0, 0, 0, 0, 0), "t5_release");
    cyc(1, 0, 0, 0, ZERO,                        "t5_end");
`else
    // Without the timeout DMA keeps the bus and D stalls throughout
    cyc(1, 0, 1, 1, ex(0, 2'b00, 0, 0, 0, 0, 1), "t6_idle");
    for (int k = 0; k < 50; k++)
      cyc(1, 0, 1, 1, ex(1, 2'b11, 0, 0, 0, 0, 1), "t6_hold");
    cyc(1, 0, 1, 0, ex(1, 2'b11, 0, 0, 0, 0, 1), "t6_br_low");
    cyc(1, 0, 1, 0, ex(0, 2'b00, 0, 0, 0, 0, 1), "t6_idle2");
    cyc(1, 0, 1, 0, ex(0, 2'b10, 1, 0, 0, 0, 1), "t6_d0");
    cyc(1, 0, 0, 0, ex(0, 2'b10, 0, 0, 1, 0, 0), "t6_d1");
    cyc(1, 0, 0, 0, ZERO,                        "t6_end");
`endif

    // Let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
